// File: rtl/part_acc_pkg.sv
// ---------------------------------------------------------------------------
// part_acc_pkg
// Shared types and arithmetic helpers for the partial-sum accumulator.
//   state_t  : control FSM states (IDLE, ACCUM)
//   acc_max  : largest signed value representable in w bits
//   acc_min  : smallest signed value representable in w bits
//   sat_add  : w-bit signed add, either clamped or wrapped
// Operands travel as MAX_W-bit sign-extended values so one function serves
// every accumulator width up to MAX_W.
// ---------------------------------------------------------------------------
package part_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;
    typedef logic signed [MAX_W:0]   wide1_t;

    function automatic wide_t acc_max(input int w);
        wide_t one;
        one = 1;
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic wide_t acc_min(input int w);
        return ~acc_max(w);
    endfunction

    // a and b must already lie inside the w-bit signed range. The extra bit in
    // the sum keeps the true result exact even for w == MAX_W.
    function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                      input logic sat, input int w);
        wide1_t sum;
        wide1_t hi;
        wide1_t lo;
        wide_t  wrapped;
        int     sh;
        sum     = wide1_t'(a) + wide1_t'(b);
        hi      = wide1_t'(acc_max(w));
        lo      = wide1_t'(acc_min(w));
        sh      = MAX_W - w;
        // Keep the low w bits and sign-extend them back to MAX_W.
        wrapped = wide_t'(sum[MAX_W-1:0]);
        wrapped = (wrapped <<< sh) >>> sh;
        if (sat && (sum > hi)) begin
            return acc_max(w);
        end else if (sat && (sum < lo)) begin
            return acc_min(w);
        end else begin
            return wrapped;
        end
    endfunction

endpackage

// File: rtl/part_acc_lane.sv
// ---------------------------------------------------------------------------
// part_acc_lane
// One independent accumulation lane: accumulator register, output register,
// sign extension of the input and the saturating/wrapping add.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : drop the running sum (group aborted)
//   first      : beat is the first of a group, so the running sum is ignored
//   beat_acc   : accepted non-last beat, update the accumulator
//   beat_last  : accepted last beat, load the output and zero the accumulator
//   in_lane    : signed IN_W input
//   out_lane   : signed ACC_W registered result
// ---------------------------------------------------------------------------
module part_acc_lane
    import part_acc_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int ACC_W = 32,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             first,
    input  logic             beat_acc,
    input  logic             beat_last,
    input  logic [IN_W-1:0]  in_lane,
    output logic [ACC_W-1:0] out_lane
);

    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] out_reg;
    logic signed [ACC_W-1:0] sum;
    wide_t                   in_ext;
    wide_t                   base_ext;

    assign in_ext   = wide_t'($signed(in_lane));
    // A group's first beat starts from zero regardless of the register, so a
    // len=1 group never picks up stale state.
    assign base_ext = first ? '0 : wide_t'(acc_reg);
    assign sum      = ACC_W'(sat_add(base_ext, in_ext, SAT != 0, ACC_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            out_reg <= '0;
        end else begin
            if (clr || beat_last) begin
                acc_reg <= '0;
            end else if (beat_acc) begin
                acc_reg <= sum;
            end
            if (beat_last) begin
                out_reg <= sum;
            end
        end
    end

    assign out_lane = out_reg;

endmodule

// File: rtl/part_accum_ctrl.sv
// ---------------------------------------------------------------------------
// part_accum_ctrl
// Multi-lane partial-sum accumulator. Sums cfg_len input beats per group and
// emits one registered result per group with valid/ready on both sides.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : abort the group in progress (no beat accepted)
//   cfg_len           : beats per group, sampled on a group's first beat, 0->1
//   in_valid/in_ready : input handshake
//   in_data           : LANES signed IN_W lanes
//   out_valid/out_ready : output handshake
//   out_data          : LANES signed ACC_W lanes
//   busy              : a group is in progress
// ---------------------------------------------------------------------------
module part_accum_ctrl
    import part_acc_pkg::*;
#(
    parameter int LANES = 9,
    parameter int IN_W  = 32,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8,
    parameter int SAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [CNT_W-1:0]       cfg_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_data,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic             out_valid_reg;
    logic [CNT_W-1:0] eff_len;
    logic             is_last;
    logic             fire;
    logic             beat_acc;
    logic             beat_last;

    assign eff_len = (cfg_len == '0) ? CNT_ONE : cfg_len;

    // Whether the beat currently offered would close the group. In IDLE the
    // length comes straight from cfg_len since len_reg is not loaded yet.
    assign is_last = (state_reg == IDLE) ? (eff_len == CNT_ONE)
                                         : (cnt_reg == (len_reg - CNT_ONE));

    // Only a closing beat needs room in the output register; a held result
    // that is being taken this cycle frees that room.
    assign in_ready  = !flush && (!is_last || !out_valid_reg || out_ready);
    assign fire      = in_valid && in_ready;
    assign beat_last = fire && is_last;
    assign beat_acc  = fire && !is_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        case (state_reg)
            IDLE: begin
                if (fire) begin
                    len_next = eff_len;
                    if (is_last) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next   = CNT_ONE;
                        state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (flush) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (fire) begin
                    if (is_last) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // A new result wins over a same-cycle handshake, giving one result per
    // cycle when groups are one beat long.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
        end else if (beat_last) begin
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            part_acc_lane #(
                .IN_W  (IN_W),
                .ACC_W (ACC_W),
                .SAT   (SAT)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .clr       (flush),
                .first     (state_reg == IDLE),
                .beat_acc  (beat_acc),
                .beat_last (beat_last),
                .in_lane   (in_data[gi*IN_W +: IN_W]),
                .out_lane  (out_data[gi*ACC_W +: ACC_W])
            );
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == ACCUM);

endmodule

// File: tb/tb_part_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_part_accum_ctrl
// Two instances share every input: dut (saturating) and dut_w (wrapping).
// Lane 0 carries d0, lanes 1..8 carry d8. Each vector drives inputs on the
// falling edge, checks in_ready before the rising edge and the registered
// outputs just after it.
// ---------------------------------------------------------------------------
module tb_part_accum_ctrl;

    localparam int LANES = 9;
    localparam int IN_W  = 32;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [CNT_W-1:0]       cfg_len;
    logic                   in_valid;
    logic                   in_ready, in_ready_w;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   out_valid, out_valid_w;
    logic                   out_ready;
    logic [LANES*ACC_W-1:0] out_data, out_data_w;
    logic                   busy, busy_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    part_accum_ctrl #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W),
                      .CNT_W(CNT_W), .SAT(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    part_accum_ctrl #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W),
                      .CNT_W(CNT_W), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .flush(flush), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .busy(busy_w)
    );

    typedef struct {
        logic       v;
        int         len;
        int         d0;
        int         d8;
        logic       ordy;
        logic       fl;
        logic       e_rdy;
        logic       e_ov;
        int         e_o0;
        int         e_w0;
        int         e_o8;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input int len, input int d0, input int d8,
                       input logic ordy, input logic fl, input logic e_rdy,
                       input logic e_ov, input int e_o0, input int e_w0,
                       input int e_o8, input logic e_busy);
        vec_t t;
        t.v = v; t.len = len; t.d0 = d0; t.d8 = d8; t.ordy = ordy; t.fl = fl;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_o0 = e_o0; t.e_w0 = e_w0;
        t.e_o8 = e_o8; t.e_busy = e_busy;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int len, input int d0,
                         input int d8, input logic ordy, input logic fl);
        in_valid  = v;
        cfg_len   = CNT_W'(len);
        out_ready = ordy;
        flush     = fl;
        for (int k = 0; k < LANES; k++) begin
            in_data[k*IN_W +: IN_W] = (k == 0) ? d0 : d8;
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_ov,
                                 input int e_o0, input int e_w0,
                                 input int e_o8, input logic e_busy);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, ".out_valid_w"}, 32'(out_valid_w), 32'(e_ov));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".lane0"}, out_data[0 +: ACC_W], e_o0);
        check({tag, ".lane0_w"}, out_data_w[0 +: ACC_W], e_w0);
        for (int k = 1; k < LANES; k++) begin
            check($sformatf("%s.lane%0d", tag, k), out_data[k*ACC_W +: ACC_W], e_o8);
        end
    endtask

    initial begin
        // ---------------- vector table ----------------
        //   v len d0            d8 ordy fl | rdy ov o0           w0           o8 busy
        // len=3: 5,-2,10 -> 13 ; lanes 1..8: 1,2,3 -> 6
        add(1, 3, 5,            1, 1, 0,   1, 0, 0,            0,            0, 1);
        add(1, 3, -2,           2, 1, 0,   1, 0, 0,            0,            0, 1);
        add(1, 3, 10,           3, 1, 0,   1, 1, 13,           13,           6, 0);
        add(0, 3, 0,            0, 1, 0,   1, 0, 13,           13,           6, 0);
        // positive overflow: sat clamps, wrap rolls over
        add(1, 2, 32'h7FFFFFF0, 0, 1, 0,   1, 0, 13,           13,           6, 1);
        add(1, 2, 32'h20,       0, 1, 0,   1, 1, 32'h7FFFFFFF, 32'h80000010, 0, 0);
        // len=1 full throughput
        add(1, 1, 1,            7, 1, 0,   1, 1, 1,            1,            7, 0);
        add(1, 1, 2,            8, 1, 0,   1, 1, 2,            2,            8, 0);
        add(1, 1, 3,            9, 1, 0,   1, 1, 3,            3,            9, 0);
        // len=2 with output backpressure
        add(0, 2, 0,            0, 0, 0,   1, 1, 3,            3,            9, 0);
        add(1, 2, 4,            1, 0, 0,   1, 1, 3,            3,            9, 1);
        add(1, 2, 6,            1, 0, 0,   0, 1, 3,            3,            9, 1);
        add(1, 2, 6,            1, 1, 0,   1, 1, 10,           10,           2, 0);
        add(0, 2, 0,            0, 1, 0,   1, 0, 10,           10,           2, 0);
        // len=4 flushed after 2 beats; mid-group cfg_len=2 must be ignored
        add(1, 4, 1,            1, 1, 0,   1, 0, 10,           10,           2, 1);
        add(1, 2, 1,            1, 1, 0,   1, 0, 10,           10,           2, 1);
        add(1, 2, 1,            1, 1, 1,   0, 0, 10,           10,           2, 0);
        add(1, 4, 1,            1, 1, 0,   1, 0, 10,           10,           2, 1);
        add(1, 4, 1,            1, 1, 0,   1, 0, 10,           10,           2, 1);
        add(1, 4, 1,            1, 1, 0,   1, 0, 10,           10,           2, 1);
        add(1, 4, 1,            1, 1, 0,   1, 1, 4,            4,            4, 0);
        // cfg_len=0 behaves as one beat
        add(1, 0, -7,           5, 1, 0,   1, 1, -7,           -7,           5, 0);
        add(0, 0, 0,            0, 1, 0,   1, 0, -7,           -7,           5, 0);
        // negative overflow
        add(1, 2, 32'h80000010, 0, 1, 0,   1, 0, -7,           -7,           5, 1);
        add(1, 2, -32,          0, 1, 0,   1, 1, 32'h80000000, 32'h7FFFFFF0, 0, 0);

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(0, 1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0);
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(vecs[i].v, vecs[i].len, vecs[i].d0, vecs[i].d8,
                  vecs[i].ordy, vecs[i].fl);
            #1;
            check({tag, ".in_ready"}, 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check_outputs(tag, vecs[i].e_ov, vecs[i].e_o0, vecs[i].e_w0,
                          vecs[i].e_o8, vecs[i].e_busy);
            $display("vec%0d v=%0b len=%0d d0=%0d rdy=%0b ov=%0b lane0=%0d busy=%0b",
                     i, vecs[i].v, vecs[i].len, vecs[i].d0, in_ready,
                     out_valid, $signed(out_data[0 +: ACC_W]), busy);
        end

        // ---------------- flush leaves a pending result alone ----------------
        @(negedge clk);
        drive(1, 3, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        check_outputs("flushpend.start", 1, 32'h80000000, 32'h7FFFFFF0, 0, 1);
        @(negedge clk);
        drive(1, 3, 1, 1, 0, 1);
        #1;
        check("flushpend.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_outputs("flushpend", 1, 32'h80000000, 32'h7FFFFFF0, 0, 0);
        $display("flushpend ov=%0b lane0=%h busy=%0b", out_valid,
                 out_data[0 +: ACC_W], busy);

        // ---------------- reset mid-group with a pending result ----------------
        @(negedge clk);
        drive(1, 3, 2, 2, 0, 0);
        @(posedge clk);
        #1;
        check("rstmid.busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 3, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outputs("rstmid", 0, 0, 0, 0, 0);
        $display("rstmid ov=%0b lane0=%h busy=%0b", out_valid,
                 out_data[0 +: ACC_W], busy);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- cfg_len=0 after reset: one-beat group ----------------
        drive(1, 0, 9, 3, 1, 0);
        #1;
        check("len0.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_outputs("len0", 1, 9, 9, 3, 0);
        $display("len0 ov=%0b lane0=%0d busy=%0b", out_valid,
                 $signed(out_data[0 +: ACC_W]), busy);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        check_outputs("len0.taken", 0, 9, 9, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/part_accum_ctrl.md
Name: part_accum_ctrl

Overview:
- Multi-lane partial-sum accumulator with handshakes; successor of the fixed 32-bit free-running accumulator.
- Sums a configurable number of input beats per group (kernel taps × input-channel tiles) and emits one result per group.
- Sits between the PE-array output and the requant/activation stage; valid/ready on both sides; optional saturating arithmetic.

Parameters:
- LANES, 9, number of independent accumulation lanes
- IN_W, 32, signed width of each input lane (IN_W <= ACC_W)
- ACC_W, 32, signed width of each accumulator/output lane
- CNT_W, 8, width of group-length counter
- SAT, 1, 1 = saturating add clamped to ACC_W signed range; 0 = two's-complement wrap

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous abort of the group in progress
- cfg_len  in  CNT_W  beats per group; sampled on the first beat of each group; 0 is treated as 1
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  LANES*IN_W  lane i at [i*IN_W +: IN_W], signed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  LANES*ACC_W  lane i at [i*ACC_W +: ACC_W], signed
- busy  out  1  group in progress (state ACCUM)

Behaviour:
- Only one clock edge is used. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE, cnt = 0, accumulator = 0, len_q = 0.
  - out_valid = 0, out_data = 0, busy = 0.
- State IDLE:
  - On the first accepted beat, latch len_q = max(cfg_len, 1).
  - If len_q == 1, the beat is the last beat.
  - Otherwise acc <= sext(in_data), cnt <= 1, go to ACCUM.
- State ACCUM:
  - Each accepted beat does acc <= acc ⊕ sext(in_data) per lane and cnt++.
  - The beat with cnt == len_q-1 is the last beat.
- Last beat (either state):
  - out_data <= acc ⊕ sext(in_data), or sext(in_data) when len_q == 1.
  - out_valid <= 1, acc <= 0, cnt <= 0, go to IDLE.
  - The result appears on the cycle after the last beat is accepted (latency 1).
- ⊕ is defined as follows:
  - SAT=1: clamp per lane to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SAT=0: wrap modulo 2^ACC_W.
  - Lanes are fully independent; no carries cross lanes.
- in_ready = !flush & (!is_last_pending | !out_valid | out_ready):
  - Non-last beats are never stalled by output backpressure.
  - A last beat stalls only while an un-taken result is held.
- Output register:
  - out_valid stays high and out_data stays stable until out_valid & out_ready.
  - A handshake without a new last beat clears out_valid.
  - A handshake in the same cycle as a new last beat reloads out_data and keeps out_valid = 1. This gives full throughput, one result per cycle when len = 1.
- flush:
  - Discards the in-progress group: acc <= 0, cnt <= 0, state IDLE.
  - in_ready is 0 that cycle, so a simultaneous in_valid is not accepted.
  - A pending out_valid/out_data is unaffected.
- cfg_len changes mid-group are ignored until the next group's first beat.
- rst mid-group or with a pending output discards everything and returns all outputs to reset values.
- busy = (state == ACCUM).

Decomposition:
- Package part_acc_pkg:
  - state enum {IDLE, ACCUM}
  - ACC_MAX/ACC_MIN constant functions of ACC_W
  - function sat_add(a, b, sat) for ACC_W operands
- Sub-module part_acc_lane:
  - One lane holding its accumulator register, sign extension and the ⊕ operation.
  - Instantiated LANES times via generate.
  - Control (FSM, counter, handshake, output valid) lives in the top.

Test Plan:
- len=3, lane0 inputs 5, -2, 10, out_ready=1 → out_valid one cycle after 3rd beat, lane0 = 13, other lanes independent.
- SAT=1, ACC_W=32, lane0 inputs 0x7FFFFFF0, 0x20 → lane0 = 0x7FFFFFFF. SAT=0 same stimulus → 0x80000010.
- len=1, continuous in_valid with values 1, 2, 3…, out_ready=1 → out_data 1, 2, 3 on consecutive cycles, in_ready never drops.
- len=2, out_ready=0 with a result pending → first beat of next group accepted, last beat stalled (in_ready=0). Raise out_ready → old result taken, new result loaded the same cycle.
- len=4, flush after 2 beats while in_valid=1 → that beat not accepted, busy=0. Next group of 4 beats of 1 yields 4, not 6.
- rst asserted mid-group with out_valid=1 → next cycle out_valid=0, out_data=0, busy=0. cfg_len=0 group → behaves as len=1.
